result_checker: RTL and testbench

- Synthesizable, parametrised self-check engine that scans the CPU/CGRA result readout port and compares each value against an on-block golden memory.
- Sweeps the row address and the lane select (vout_addr), counts mismatches and records the first failure.
- Sits beside the CPU top. Drives address/vout_addr/DataOrReg; consumes value_o.
- Generalises the fixed 64-pattern, 4-lane, 8-bit, 234-cycle-delay check in width, depth, lane count and latency.

---
 rtl/checker_pkg.sv | 32 +++
 rtl/checker_delay_pipe.sv | 33 +++
 rtl/result_checker.sv | 219 +++++++++++++++++++++
 tb/tb_result_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared types, default sizing and the pattern-index to (row address, lane) mapping
// used by the result checker.
package checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_LANES       = 4;
    localparam int DEF_LANE_W      = 2;
    localparam int DEF_ROWS        = 16;
    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_BASE_ADDR   = 8;
    localparam int DEF_START_DELAY = 234;
    localparam int DEF_READ_LAT    = 1;
    localparam int DEF_CNT_W       = 8;

    // Lanes are read highest first; the row advances once every lane of it has been read.
    function automatic int map_addr(input int j, input int lanes, input int base);
        return base + (j / lanes);
    endfunction

    function automatic int map_lane(input int j, input int lanes);
        return lanes - 1 - (j % lanes);
    endfunction

endpackage

// File: rtl/checker_delay_pipe.sv
// Fixed-depth shift register carrying (valid, pattern index, golden value) so each
// compare lines up with the CPU read latency.
module checker_delay_pipe #(
    parameter int DEPTH  = 1,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] gld_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [DATA_W-1:0] gld_o
);

    localparam int STAGE_W = 1 + IDX_W + DATA_W;

    logic [DEPTH*STAGE_W-1:0] pipe_q;

    // New stage enters at the bottom; the oldest stage falls off the top.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (DEPTH*STAGE_W)'({pipe_q, valid_i, idx_i, gld_i});
        end
    end

    assign {valid_o, idx_o, gld_o} = pipe_q[DEPTH*STAGE_W-1 -: STAGE_W];

endmodule

// File: rtl/result_checker.sv
// Self-check engine: sweeps CPU readout (row address x lane) against a golden RAM.
// Define RESULT_CHECKER_ERR_MAP_EN to add the per-pattern err_map_o bitmap.
module result_checker
    import checker_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LANES       = DEF_LANES,
    parameter int LANE_W      = DEF_LANE_W,
    parameter int ROWS        = DEF_ROWS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int START_DELAY = DEF_START_DELAY,
    parameter int READ_LAT    = DEF_READ_LAT,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int N          = ROWS * LANES,
    localparam int IDX_W      = $clog2(ROWS * LANES)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              start_i,
    input  logic              gld_we_i,
    input  logic [IDX_W-1:0]  gld_waddr_i,
    input  logic [DATA_W-1:0] gld_wdata_i,
    output logic              data_sel_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LANE_W-1:0] lane_o,
    input  logic [DATA_W-1:0] value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [IDX_W-1:0]  ferr_idx_o,
    output logic [DATA_W-1:0] ferr_got_o,
    output logic [DATA_W-1:0] ferr_exp_o
`ifdef RESULT_CHECKER_ERR_MAP_EN
    ,
    output logic [N-1:0]      err_map_o
`endif
);

    // Wide enough for the start delay and for the drain count (READ_LAT-1 <= 2).
    localparam int DLY_W = $clog2(START_DELAY + 4);

    state_t            state_q;
    logic [DLY_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LANE_W-1:0] lane_q;
    logic              dataSel_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  errCnt_q;
    logic [CNT_W-1:0]  errCnt_d;
    logic              ferrSeen_q;
    logic [IDX_W-1:0]  ferrIdx_q;
    logic [DATA_W-1:0] ferrGot_q;
    logic [DATA_W-1:0] ferrExp_q;

    logic [DATA_W-1:0] gldMem [N];

    logic              startAccept;
    logic              pipeValid;
    logic [IDX_W-1:0]  pipeIdx;
    logic [DATA_W-1:0] pipeGld;
    logic              mismatch;
    logic              errHit;
    logic [ADDR_W-1:0] nextAddr;
    logic [LANE_W-1:0] nextLane;

    assign startAccept = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk_i) begin
        if (gld_we_i && !busy_q) begin
            gldMem[gld_waddr_i] <= gld_wdata_i;
        end
    end

    checker_delay_pipe #(
        .DEPTH  (READ_LAT),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk_i   (clk_i),
        .reset   (reset),
        .valid_i (state_q == SCAN),
        .idx_i   (idx_q),
        .gld_i   (gldMem[idx_q]),
        .valid_o (pipeValid),
        .idx_o   (pipeIdx),
        .gld_o   (pipeGld)
    );

    // In simulation an X/Z readback must count as a mismatch rather than propagate X.
`ifdef SYNTHESIS
    assign mismatch = (value_i != pipeGld);
`else
    assign mismatch = (value_i !== pipeGld);
`endif

    assign errHit = pipeValid && mismatch;

    always_comb begin
        errCnt_d = errCnt_q;
        if (errHit && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
        nextAddr = ADDR_W'(map_addr(int'(idx_q) + 1, LANES, BASE_ADDR));
        nextLane = LANE_W'(map_lane(int'(idx_q) + 1, LANES));
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            lane_q     <= LANE_W'(LANES - 1);
            dataSel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCnt_q   <= '0;
            ferrSeen_q <= 1'b0;
            ferrIdx_q  <= '0;
            ferrGot_q  <= '0;
            ferrExp_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            errCnt_q <= errCnt_d;
            if (errHit && !ferrSeen_q) begin
                ferrSeen_q <= 1'b1;
                ferrIdx_q  <= pipeIdx;
                ferrGot_q  <= value_i;
                ferrExp_q  <= pipeGld;
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= WAIT;
                        cnt_q      <= DLY_W'(START_DELAY);
                        idx_q      <= '0;
                        addr_q     <= ADDR_W'(map_addr(0, LANES, BASE_ADDR));
                        lane_q     <= LANE_W'(map_lane(0, LANES));
                        dataSel_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        errCnt_q   <= '0;
                        ferrSeen_q <= 1'b0;
                        ferrIdx_q  <= '0;
                        ferrGot_q  <= '0;
                        ferrExp_q  <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= SCAN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SCAN: begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_q <= DRAIN;
                        cnt_q   <= DLY_W'(READ_LAT - 1);
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        addr_q <= nextAddr;
                        lane_q <= nextLane;
                    end
                end
                DRAIN: begin
                    // The last compare registers on this same edge, so judge pass on the next count.
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        dataSel_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (errCnt_d == '0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RESULT_CHECKER_ERR_MAP_EN
    logic [N-1:0] errMap_q;

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            errMap_q <= '0;
        end else if (startAccept) begin
            errMap_q <= '0;
        end else if (errHit) begin
            errMap_q[pipeIdx] <= 1'b1;
        end
    end

    assign err_map_o = errMap_q;
`endif

    assign data_sel_o = dataSel_q;
    assign addr_o     = addr_q;
    assign lane_o     = lane_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = errCnt_q;
    assign ferr_idx_o = ferrIdx_q;
    assign ferr_got_o = ferrGot_q;
    assign ferr_exp_o = ferrExp_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: a default instance (READ_LAT=1, 234-cycle delay)
// and a small-counter instance (CNT_W=2, READ_LAT=2) each read a behavioural CPU model.
module tb_result_checker;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startA;
    logic       startB;
    logic       gldWe;
    logic [5:0] gldWaddr;
    logic [7:0] gldWdata;

    logic       dataSelA, busyA, doneA, passA;
    logic [4:0] addrA;
    logic [1:0] laneA;
    logic [7:0] valA;
    logic [7:0] errCntA;
    logic [5:0] ferrIdxA;
    logic [7:0] ferrGotA, ferrExpA;

    logic       dataSelB, busyB, doneB, passB;
    logic [4:0] addrB;
    logic [1:0] laneB;
    logic [7:0] valB, valB1;
    logic [1:0] errCntB;
    logic [5:0] ferrIdxB;
    logic [7:0] ferrGotB, ferrExpB;

`ifdef RESULT_CHECKER_ERR_MAP_EN
    logic [63:0] mapA, mapB;
`endif

    logic [7:0] cpuMemA [64];
    logic [7:0] cpuMemB [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_checker dut (
        .clk_i       (clk),
        .reset       (resetN),
        .start_i     (startA),
        .gld_we_i    (gldWe),
        .gld_waddr_i (gldWaddr),
        .gld_wdata_i (gldWdata),
        .data_sel_o  (dataSelA),
        .addr_o      (addrA),
        .lane_o      (laneA),
        .value_i     (valA),
        .busy_o      (busyA),
        .done_o      (doneA),
        .pass_o      (passA),
        .err_cnt_o   (errCntA),
        .ferr_idx_o  (ferrIdxA),
        .ferr_got_o  (ferrGotA),
        .ferr_exp_o  (ferrExpA)
`ifdef RESULT_CHECKER_ERR_MAP_EN
        ,
        .err_map_o   (mapA)
`endif
    );

    result_checker #(
        .CNT_W       (2),
        .START_DELAY (3),
        .READ_LAT    (2)
    ) dutSat (
        .clk_i       (clk),
        .reset       (resetN),
        .start_i     (startB),
        .gld_we_i    (gldWe),
        .gld_waddr_i (gldWaddr),
        .gld_wdata_i (gldWdata),
        .data_sel_o  (dataSelB),
        .addr_o      (addrB),
        .lane_o      (laneB),
        .value_i     (valB),
        .busy_o      (busyB),
        .done_o      (doneB),
        .pass_o      (passB),
        .err_cnt_o   (errCntB),
        .ferr_idx_o  (ferrIdxB),
        .ferr_got_o  (ferrGotB),
        .ferr_exp_o  (ferrExpB)
`ifdef RESULT_CHECKER_ERR_MAP_EN
        ,
        .err_map_o   (mapB)
`endif
    );

    // CPU readout: row 8 holds patterns 0..3 with lane 3 first.
    function automatic int locToIdx(input logic [4:0] a, input logic [1:0] l);
        return (int'(a) - 8) * 4 + (3 - int'(l));
    endfunction

    function automatic logic [7:0] readA(input logic [4:0] a, input logic [1:0] l);
        int j;
        j = locToIdx(a, l);
        return (j >= 0 && j < 64) ? cpuMemA[j] : 8'h00;
    endfunction

    function automatic logic [7:0] readB(input logic [4:0] a, input logic [1:0] l);
        int j;
        j = locToIdx(a, l);
        return (j >= 0 && j < 64) ? cpuMemB[j] : 8'h00;
    endfunction

    // One-cycle CPU read latency for the default instance, two for the small one.
    always @(posedge clk) begin
        valA  <= readA(addrA, laneA);
        valB1 <= readB(addrB, laneB);
        valB  <= valB1;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, ":addr_o"}, 64'(addrA), 64'd8);
        checkOutput({tag, ":lane_o"}, 64'(laneA), 64'd3);
        checkOutput({tag, ":data_sel_o"}, 64'(dataSelA), 64'd0);
        checkOutput({tag, ":busy_o"}, 64'(busyA), 64'd0);
        checkOutput({tag, ":done_o"}, 64'(doneA), 64'd0);
        checkOutput({tag, ":pass_o"}, 64'(passA), 64'd0);
        checkOutput({tag, ":err_cnt_o"}, 64'(errCntA), 64'd0);
        checkOutput({tag, ":ferr_idx_o"}, 64'(ferrIdxA), 64'd0);
        checkOutput({tag, ":ferr_got_o"}, 64'(ferrGotA), 64'd0);
        checkOutput({tag, ":ferr_exp_o"}, 64'(ferrExpA), 64'd0);
`ifdef RESULT_CHECKER_ERR_MAP_EN
        checkOutput({tag, ":err_map_o"}, mapA, 64'd0);
`endif
    endtask

    // Pulse start on the default instance, optionally with a same-cycle golden write of j=40.
    task automatic applyStimulus(input bit withWrite);
        startA = 1'b1;
        if (withWrite) begin
            gldWe    = 1'b1;
            gldWaddr = 6'd40;
            gldWdata = 8'h77;
        end
        stepCycle();
        startA = 1'b0;
        gldWe  = 1'b0;
    endtask

    // Count cycles from the start edge to done_o; optionally check scan order and poke mid-scan.
    task automatic waitDoneA(input int expLat, input bit checkOrder, input int pokeAt);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            stepCycle();
            n++;
            if (checkOrder && n >= 235 && n <= 298) begin
                checkOutput("scan:addr_o", 64'(addrA), 64'(8 + (n - 235) / 4));
                checkOutput("scan:lane_o", 64'(laneA), 64'(3 - (n - 235) % 4));
            end
            if (pokeAt > 0 && n == pokeAt) begin
                startA   = 1'b1;
                gldWe    = 1'b1;
                gldWaddr = 6'd7;
                gldWdata = 8'h99;
            end else if (pokeAt > 0 && n == pokeAt + 1) begin
                startA = 1'b0;
                gldWe  = 1'b0;
            end
            if (doneA === 1'b1) seen = 1'b1;
        end
        checkOutput("done_latency", 64'(n), 64'(expLat));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        resetN   = 1'b0;
        startA   = 1'b0;
        startB   = 1'b0;
        gldWe    = 1'b0;
        gldWaddr = '0;
        gldWdata = '0;
        for (int j = 0; j < 64; j++) begin
            cpuMemA[j] = 8'(j);
            cpuMemB[j] = ~8'(j);
        end
        repeat (3) stepCycle();
        checkResetA("reset");

        resetN = 1'b1;
        stepCycle();
        for (int j = 0; j < 64; j++) begin
            gldWe    = 1'b1;
            gldWaddr = 6'(j);
            gldWdata = 8'(j);
            stepCycle();
        end
        gldWe = 1'b0;

        $display("[TB] clean sweep with scan-order check");
        applyStimulus(1'b0);
        checkOutput("start:busy_o", 64'(busyA), 64'd1);
        checkOutput("start:data_sel_o", 64'(dataSelA), 64'd1);
        waitDoneA(300, 1'b1, 0);
        checkOutput("clean:pass_o", 64'(passA), 64'd1);
        checkOutput("clean:err_cnt_o", 64'(errCntA), 64'd0);
        checkOutput("clean:busy_o", 64'(busyA), 64'd0);
        checkOutput("clean:data_sel_o", 64'(dataSelA), 64'd0);
        stepCycle();
        checkOutput("clean:done_pulse", 64'(doneA), 64'd0);
        checkOutput("clean:pass_held", 64'(passA), 64'd1);

        $display("[TB] two corrupted readbacks");
        cpuMemA[5]  = 8'hAA;
        cpuMemA[40] = 8'h77;
        applyStimulus(1'b0);
        checkOutput("restart:pass_cleared", 64'(passA), 64'd0);
        waitDoneA(300, 1'b0, 0);
        checkOutput("bad:err_cnt_o", 64'(errCntA), 64'd2);
        checkOutput("bad:ferr_idx_o", 64'(ferrIdxA), 64'd5);
        checkOutput("bad:ferr_got_o", 64'(ferrGotA), 64'hAA);
        checkOutput("bad:ferr_exp_o", 64'(ferrExpA), 64'h05);
        checkOutput("bad:pass_o", 64'(passA), 64'd0);
`ifdef RESULT_CHECKER_ERR_MAP_EN
        checkOutput("bad:err_map_o", mapA, 64'h0000_0100_0000_0020);
`endif

        $display("[TB] start and golden write while busy");
        applyStimulus(1'b0);
        waitDoneA(300, 1'b0, 250);
        checkOutput("busy:err_cnt_o", 64'(errCntA), 64'd2);
        checkOutput("busy:ferr_idx_o", 64'(ferrIdxA), 64'd5);

        $display("[TB] saturating counter instance");
        startB = 1'b1;
        stepCycle();
        startB = 1'b0;
        n = 0;
        while (doneB !== 1'b1 && n < 1000) begin
            stepCycle();
            n++;
        end
        checkOutput("sat:done_latency", 64'(n), 64'd70);
        checkOutput("sat:err_cnt_o", 64'(errCntB), 64'd3);
        checkOutput("sat:pass_o", 64'(passB), 64'd0);
        checkOutput("sat:busy_o", 64'(busyB), 64'd0);
        checkOutput("sat:data_sel_o", 64'(dataSelB), 64'd0);
        checkOutput("sat:ferr_idx_o", 64'(ferrIdxB), 64'd0);
        checkOutput("sat:ferr_got_o", 64'(ferrGotB), 64'hFF);
        checkOutput("sat:ferr_exp_o", 64'(ferrExpB), 64'h00);
`ifdef RESULT_CHECKER_ERR_MAP_EN
        checkOutput("sat:err_map_o", mapB, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        $display("[TB] reset at j=20");
        applyStimulus(1'b0);
        repeat (255) stepCycle();
        checkOutput("midrst:err_before", 64'(errCntA), 64'd1);
        resetN = 1'b0;
        #1;
        checkResetA("midrst");
        repeat (3) begin
            stepCycle();
            checkOutput("midrst:no_done", 64'(doneA), 64'd0);
        end
        resetN = 1'b1;
        stepCycle();
        checkOutput("postrst:busy_o", 64'(busyA), 64'd0);

        $display("[TB] restart with same-cycle golden write");
        applyStimulus(1'b1);
        waitDoneA(300, 1'b0, 0);
        checkOutput("final:err_cnt_o", 64'(errCntA), 64'd1);
        checkOutput("final:ferr_idx_o", 64'(ferrIdxA), 64'd5);
        checkOutput("final:ferr_got_o", 64'(ferrGotA), 64'hAA);
        checkOutput("final:ferr_exp_o", 64'(ferrExpA), 64'h05);
        checkOutput("final:pass_o", 64'(passA), 64'd0);
`ifdef RESULT_CHECKER_ERR_MAP_EN
        checkOutput("final:err_map_o", mapA, 64'h0000_0000_0000_0020);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
